// File: rtl/vend_pkg.sv
// Shared vending types: coin encoding, coin value helper, dispenser state.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package vend_pkg;

  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    COIN_2    = 2'b01,
    COIN_3    = 2'b10,
    COIN_4    = 2'b11
  } coin_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_DISPENSE,
    ST_DONE,
    ST_FAULT
  } state_t;

  // Face value of a coin in price units; COIN_NONE is worth nothing.
  function automatic logic [2:0] coin_value(input coin_t c);
    case (c)
      COIN_2:  return 3'd2;
      COIN_3:  return 3'd3;
      COIN_4:  return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/change_coin_select.sv
// Greedy coin picker: largest in-stock coin that leaves 0 or >=2 units owed.
// Latency: combinational.
// Backpressure: none.
module change_coin_select
  import vend_pkg::*;
#(
  parameter int VAL_W   = 4,
  parameter int STOCK_W = 4
) (
  input  logic [VAL_W-1:0]   r,
  input  logic [STOCK_W-1:0] stock2,
  input  logic [STOCK_W-1:0] stock3,
  input  logic [STOCK_W-1:0] stock4,
  output coin_t              coin,
  output logic               found
);

  // A remainder of exactly 1 unit can never be paid, so a coin is only usable
  // if it clears the debt or leaves at least the smallest coin's worth.
  function automatic logic fits(input logic [VAL_W-1:0] rem, input logic [2:0] v);
    logic [VAL_W-1:0] vx;
    logic [VAL_W-1:0] d;
    vx = VAL_W'(v);
    d  = rem - vx;
    return (vx <= rem) && ((d == '0) || (d >= VAL_W'(2)));
  endfunction

  // Scan 4, 3, 2 and take the first coin that is stocked and fits.
  always_comb begin
    coin  = COIN_NONE;
    found = 1'b0;
    if ((stock4 != '0) && fits(r, 3'd4)) begin
      coin  = COIN_4;
      found = 1'b1;
    end else if ((stock3 != '0) && fits(r, 3'd3)) begin
      coin  = COIN_3;
      found = 1'b1;
    end else if ((stock2 != '0) && fits(r, 3'd2)) begin
      coin  = COIN_2;
      found = 1'b1;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Pays out a credit amount as coins to a hopper, tracking per-coin stock.
// Latency: first coin_valid 2 cycles after an accepted start; ack -> SELECT -> next coin.
// Backpressure: coin held on coin_valid until coin_ack; faults after ACK_TIMEOUT idle cycles.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int VAL_W       = 4,
  parameter int STOCK_W     = 4,
  parameter int INIT_STOCK  = 8,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [VAL_W-1:0] amount,
  input  logic             refill,
  input  logic             coin_ack,
  output logic [1:0]       coin_out,
  output logic             coin_valid,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [VAL_W-1:0] remaining
);

  localparam int TO_W = $clog2(ACK_TIMEOUT + 1);

  state_t             state;
  state_t             state_nx;
  logic [VAL_W-1:0]   remaining_q;
  logic [STOCK_W-1:0] stock2;
  logic [STOCK_W-1:0] stock3;
  logic [STOCK_W-1:0] stock4;
  logic [TO_W-1:0]    tcnt;
  coin_t              coin_q;
  coin_t              sel_coin;
  logic               sel_found;

  change_coin_select #(
    .VAL_W   (VAL_W),
    .STOCK_W (STOCK_W)
  ) u_select (
    .r      (remaining_q),
    .stock2 (stock2),
    .stock3 (stock3),
    .stock4 (stock4),
    .coin   (sel_coin),
    .found  (sel_found)
  );

  // State register; reset aborts any payout in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  // Next-state logic for the payout sequence.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:     if (start) state_nx = ST_SELECT;
      ST_SELECT: begin
        if (remaining_q == '0) state_nx = ST_DONE;
        else if (sel_found)    state_nx = ST_DISPENSE;
        else                   state_nx = ST_FAULT;
      end
      ST_DISPENSE: begin
        if (coin_ack)                              state_nx = ST_SELECT;
        else if (tcnt == TO_W'(ACK_TIMEOUT - 1))   state_nx = ST_FAULT;
      end
      ST_DONE:     state_nx = ST_IDLE;
      ST_FAULT:    state_nx = ST_IDLE;
      default:     state_nx = ST_IDLE;
    endcase
  end

  // Datapath: capture amount, latch the chosen coin, deduct on ack, refill stock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      remaining_q <= '0;
      stock2      <= STOCK_W'(INIT_STOCK);
      stock3      <= STOCK_W'(INIT_STOCK);
      stock4      <= STOCK_W'(INIT_STOCK);
      tcnt        <= '0;
      coin_q      <= COIN_NONE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) remaining_q <= amount;
          if (refill) begin
            stock2 <= STOCK_W'(INIT_STOCK);
            stock3 <= STOCK_W'(INIT_STOCK);
            stock4 <= STOCK_W'(INIT_STOCK);
          end
        end
        ST_SELECT: begin
          if (sel_found) coin_q <= sel_coin;
          tcnt <= '0;
        end
        ST_DISPENSE: begin
          if (coin_ack) begin
            remaining_q <= remaining_q - VAL_W'(coin_value(coin_q));
            case (coin_q)
              COIN_2:  if (stock2 != '0) stock2 <= stock2 - 1'b1;
              COIN_3:  if (stock3 != '0) stock3 <= stock3 - 1'b1;
              COIN_4:  if (stock4 != '0) stock4 <= stock4 - 1'b1;
              default: ;
            endcase
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign coin_valid = (state == ST_DISPENSE);
  assign coin_out   = coin_valid ? coin_q : COIN_NONE;
  assign busy       = (state != ST_IDLE);
  assign done       = (state == ST_DONE);
  assign error      = (state == ST_FAULT);
  assign remaining  = remaining_q;

endmodule

// File: tb/tb_change_dispenser.sv
module tb_change_dispenser;
  import vend_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] amount = '0;
  logic       refill = 1'b0;
  logic       coin_ack = 1'b0;
  logic [1:0] coin_out;
  logic       coin_valid;
  logic       busy;
  logic       done;
  logic       error;
  logic [3:0] remaining;

  int n_cmp = 0;
  int n_bad = 0;

  // standalone selector for table checks of the greedy rule
  logic [3:0] u_r;
  logic [3:0] u_s4;
  coin_t      u_coin;
  logic       u_found;

  always #5 clk = ~clk;

  change_dispenser #(
    .VAL_W(4), .STOCK_W(4), .INIT_STOCK(8), .ACK_TIMEOUT(15)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .amount     (amount),
    .refill     (refill),
    .coin_ack   (coin_ack),
    .coin_out   (coin_out),
    .coin_valid (coin_valid),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .remaining  (remaining)
  );

  change_coin_select #(.VAL_W(4), .STOCK_W(4)) u_sel (
    .r      (u_r),
    .stock2 (4'd8),
    .stock3 (4'd8),
    .stock4 (u_s4),
    .coin   (u_coin),
    .found  (u_found)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic pulse_start(input logic [3:0] amt);
    amount = amt;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  // Run one payout, acking each coin one cycle after it appears.
  task automatic pay(input logic [3:0] amt, input int ncoins,
                     input logic [1:0] c0, input logic [1:0] c1, input logic [1:0] c2,
                     input bit exp_err);
    logic [1:0] ec[3];
    int got;
    bit fin;
    ec[0] = c0; ec[1] = c1; ec[2] = c2;
    got = 0;
    fin = 0;
    pulse_start(amt);
    for (int cyc = 0; cyc < 60 && !fin; cyc++) begin
      tick();
      if (coin_valid) begin
        if (got < ncoins) chk("coin", coin_out, ec[got]);
        else              chk("coin_count", got + 1, ncoins);
        got++;
        tick();
        chk("coin_held", coin_out, (got <= ncoins) ? ec[got-1] : coin_out);
        coin_ack = 1'b1;
        tick();
        coin_ack = 1'b0;
        chk("valid_drop", coin_valid, 0);
      end else if (done || error) begin
        fin = 1;
        chk("done", done, !exp_err);
        chk("error", error, exp_err);
      end
    end
    if (!fin) chk("pay_timeout", 0, 1);
    chk("ncoins", got, ncoins);
    tick();
    chk("idle", busy, 0);
  endtask

  initial begin
    int vcnt;
    bit seen_err;

    // selector table
    u_s4 = 4'd8;
    u_r = 4'd5; #1; chk("sel5",  {u_found, u_coin}, {1'b1, COIN_3});
    u_r = 4'd6; #1; chk("sel6",  {u_found, u_coin}, {1'b1, COIN_4});
    u_r = 4'd7; #1; chk("sel7",  {u_found, u_coin}, {1'b1, COIN_4});
    u_r = 4'd1; #1; chk("sel1",  {u_found, u_coin}, {1'b0, COIN_NONE});
    u_r = 4'd2; #1; chk("sel2",  {u_found, u_coin}, {1'b1, COIN_2});
    u_s4 = 4'd0; u_r = 4'd4; #1; chk("sel4_nostock", {u_found, u_coin}, {1'b1, COIN_2});

    // reset state
    #2;
    chk("rst_valid", coin_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_coin", coin_out, 0);
    chk("rst_done_err", {done, error}, 0);
    chk("rst_rem", remaining, 0);
    chk("rst_stock", {dut.stock4, dut.stock3, dut.stock2}, {4'd8, 4'd8, 4'd8});
    do_reset();

    // 1: 5 -> 3 then 2
    pay(4'd5, 2, COIN_3, COIN_2, COIN_NONE, 0);
    chk("t1_rem", remaining, 0);
    chk("t1_stock3", dut.stock3, 7);
    chk("t1_stock2", dut.stock2, 7);
    chk("t1_stock4", dut.stock4, 8);

    // 2: 7 -> 4 then 3; 1 is unpayable
    pay(4'd7, 2, COIN_4, COIN_3, COIN_NONE, 0);
    chk("t2_stock4", dut.stock4, 7);
    pay(4'd1, 0, COIN_NONE, COIN_NONE, COIN_NONE, 1);
    chk("t2_rem", remaining, 1);

    // 3: no ack -> 15 cycles of valid then fault, no deduction
    do_reset();
    pulse_start(4'd4);
    chk("t3_select_no_valid", coin_valid, 0);
    vcnt = 0;
    seen_err = 0;
    for (int cyc = 0; cyc < 40 && !seen_err; cyc++) begin
      tick();
      if (coin_valid) begin
        vcnt++;
        if (vcnt == 1) chk("t3_coin", coin_out, COIN_4);
      end
      if (error) seen_err = 1;
    end
    chk("t3_err", seen_err, 1);
    chk("t3_vcnt", vcnt, 15);
    chk("t3_rem", remaining, 4);
    chk("t3_stock4", dut.stock4, 8);
    tick();

    // 4: drain coin 4, then 4 pays as 2+2
    for (int i = 0; i < 8; i++) pay(4'd4, 1, COIN_4, COIN_NONE, COIN_NONE, 0);
    chk("t4_drained", dut.stock4, 0);
    pay(4'd4, 2, COIN_2, COIN_2, COIN_NONE, 0);
    chk("t4_stock2", dut.stock2, 6);

    // 5: zero amount -> done two cycles after start
    pulse_start(4'd0);
    chk("t5_busy", busy, 1);
    chk("t5_early_done", done, 0);
    tick();
    chk("t5_done", done, 1);
    chk("t5_novalid", coin_valid, 0);
    tick();
    chk("t5_idle", {busy, done}, 0);
    // start while busy is ignored
    pulse_start(4'd2);
    tick();
    chk("t5b_coin", {coin_valid, coin_out}, {1'b1, COIN_2});
    pulse_start(4'd9);
    chk("t5b_rem_kept", remaining, 2);
    chk("t5b_coin_kept", coin_out, COIN_2);
    coin_ack = 1'b1;
    tick();
    coin_ack = 1'b0;
    tick();
    chk("t5b_done", done, 1);
    chk("t5b_rem", remaining, 0);
    chk("t5b_stock2", dut.stock2, 5);
    tick();

    // 6: reset mid-dispense aborts at once
    pulse_start(4'd6);
    tick();
    chk("t6_dispensing", coin_valid, 1);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_out", {coin_valid, busy, done, error, coin_out}, 0);
    chk("t6_rst_rem", remaining, 0);
    chk("t6_rst_stock", {dut.stock4, dut.stock3, dut.stock2}, {4'd8, 4'd8, 4'd8});
    tick();
    reset_n = 1'b1;
    tick();
    pay(4'd4, 1, COIN_4, COIN_NONE, COIN_NONE, 0);
    pay(4'd5, 2, COIN_3, COIN_2, COIN_NONE, 0);
    chk("t6_drained", {dut.stock4, dut.stock3, dut.stock2}, {4'd7, 4'd7, 4'd7});
    refill = 1'b1;
    tick();
    refill = 1'b0;
    chk("t6_refill", {dut.stock4, dut.stock3, dut.stock2}, {4'd8, 4'd8, 4'd8});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "global timeout");
  end

endmodule
